// File: rtl/signed_restore.sv
// Purpose: rebuilds a signed two's-complement value from magnitude + sign, one bit per clock, saturating unrepresentable results.
// Latency: accept edge t0, result/status/o_done visible in the cycle after edge tM; one conversion per M+2 cycles.
// Backpressure: none; i_start is honoured only in IDLE, and requests during CONV/DONE are dropped (not queued).
//
// Ports:
//   i_clk, i_rst       clock and synchronous active-high reset
//   i_start            start request, sampled only in IDLE
//   i_mag [K-1:0]      unsigned magnitude, sampled on the accepting edge
//   i_sign             1 = negative, sampled on the accepting edge
//   o_result [M-1:0]   signed result, held between conversions
//   o_status [3:0]     {negative, all ones, even nonzero popcount, overflow}
//   o_busy             high while converting and in the DONE cycle
//   o_done             one-cycle pulse when o_result/o_status are updated
module signed_restore #(
    parameter int M = 8,
    parameter int K = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [K-1:0]        i_mag,
    input  logic                i_sign,
    output logic signed [M-1:0] o_result,
    output logic [3:0]          o_status,
    output logic                o_busy,
    output logic                o_done
);

    localparam int CW = $clog2(M + 1);
    // Wide enough to compare the full K-bit magnitude against 2^(M-1).
    localparam int W  = ((K > M) ? K : M) + 1;
    localparam logic [W-1:0] HALF = W'(1) << (M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [M-1:0]  work;      // consumed from bit 0, produced bits enter at the MSB
    logic          sign_q;
    logic          seen;      // a 1 has already passed through the negate stage
    logic          ovf_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] ones;

    logic          bit_in;
    logic          bit_out;
    logic [M-1:0]  work_nxt;
    logic [CW-1:0] ones_nxt;
    logic          last;
    logic [M-1:0]  res_fin;
    logic [CW-1:0] ones_fin;
    logic [W-1:0]  mag_w;
    logic          ovf_acc;

    always_comb begin
        bit_in   = work[0];
        // Serial negate: bits up to and including the first 1 pass, later bits invert.
        bit_out  = bit_in ^ (sign_q & seen);
        work_nxt = {bit_out, work[M-1:1]};
        ones_nxt = ones + CW'(bit_out);
        last     = (cnt == CW'(M - 1));

        res_fin  = work_nxt;
        ones_fin = ones_nxt;
        if (ovf_q) begin
            if (sign_q) begin
                res_fin  = {1'b1, {(M-1){1'b0}}};
                ones_fin = CW'(1);
            end else begin
                res_fin  = {1'b0, {(M-1){1'b1}}};
                ones_fin = CW'(M - 1);
            end
        end

        mag_w   = W'(i_mag);
        // Negative range reaches one further than positive: -2^(M-1) is representable.
        ovf_acc = i_sign ? (mag_w > HALF) : (mag_w > (HALF - W'(1)));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            work     <= '0;
            sign_q   <= 1'b0;
            seen     <= 1'b0;
            ovf_q    <= 1'b0;
            cnt      <= '0;
            ones     <= '0;
            o_result <= '0;
            o_status <= 4'b0000;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        work   <= M'(i_mag);
                        sign_q <= i_sign;
                        seen   <= 1'b0;
                        cnt    <= '0;
                        ones   <= '0;
                        ovf_q  <= ovf_acc;
                        o_busy <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    work <= work_nxt;
                    seen <= seen | bit_in;
                    ones <= ones_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        o_result <= res_fin;
                        o_status <= {res_fin[M-1],
                                     &res_fin,
                                     (ones_fin != '0) & ~ones_fin[0],
                                     ovf_q};
                        o_done   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
